// File: rtl/entropy_src_seed_sm.sv
// Seed sequencer for the entropy source: decides when health-tested windows become
// a conditioned seed across boot/bypass, startup, continuous and firmware-override modes.
module entropy_src_seed_sm #(
  parameter int unsigned StartupWindows     = 2,
  parameter int unsigned StartupFailLimit   = 2,
  parameter int unsigned ContWindowsPerSeed = 1,
  parameter int unsigned CntW               = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            bypass_mode_i,
  input  logic            fw_ov_ent_insert_i,
  input  logic            fw_ov_sha3_start_i,
  input  logic            ht_done_pulse_i,
  input  logic            ht_fail_pulse_i,
  input  logic            alert_thresh_fail_i,
  input  logic            bypass_stage_rdy_i,
  input  logic            sha3_state_vld_i,
  input  logic            local_escalate_i,
  output logic            rst_alert_cntr_o,
  output logic            main_stage_push_o,
  output logic            bypass_stage_pop_o,
  output logic            boot_phase_done_o,
  output logic            sha3_start_o,
  output logic            sha3_process_o,
  output logic [3:0]      sha3_done_o,
  output logic            startup_done_o,
  output logic [CntW-1:0] pass_cnt_o,
  output logic [CntW-1:0] fail_cnt_o,
  output logic            main_sm_alert_o,
  output logic            main_sm_idle_o,
  output logic            main_sm_err_o
);

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  // Sparse codes so a single upset cannot land on another legal state.
  typedef enum logic [7:0] {
    StIdle           = 8'hA6,
    StBootHtRunning  = 8'h3C,
    StBootPostHtChk  = 8'h59,
    StBootPhaseDone  = 8'hC3,
    StStartupHtStart = 8'h95,
    StStartupRun     = 8'h6A,
    StContHtStart    = 8'h1E,
    StContHtRunning  = 8'hE1,
    StFwInsertStart  = 8'h4B,
    StFwInsertMsg    = 8'hB4,
    StSha3Process    = 8'h27,
    StSha3Valid      = 8'hD8,
    StSha3Done       = 8'h72,
    StSha3MsgDone    = 8'h8D,
    StAlertState     = 8'h36,
    StAlertHang      = 8'hC9,
    StError          = 8'hFF
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_pass_cnt;
  logic [CntW-1:0]   r_fail_cnt;
  logic              r_startup_done;
  logic [CntW-1:0]   w_pass_d;
  logic [CntW-1:0]   w_fail_d;
  logic              w_startup_done_d;
  logic [CntW-1:0]   w_pass_inc;
  logic [CntW-1:0]   w_fail_inc;
  logic              w_abortable;
  logic              w_rst_alert;
  logic              w_push;
  logic              w_pop;
  logic              w_sha3_start;
  logic [3:0]        w_sha3_done;

  assign w_pass_inc  = (r_pass_cnt == '1) ? r_pass_cnt : r_pass_cnt + 1'b1;
  assign w_fail_inc  = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + 1'b1;
  assign w_abortable = !(r_state inside {StSha3Process, StSha3Valid, StSha3Done,
                                         StAlertState, StError});

  always_comb begin
    w_state_d        = r_state;
    w_pass_d         = r_pass_cnt;
    w_fail_d         = r_fail_cnt;
    w_startup_done_d = r_startup_done;
    w_rst_alert      = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_sha3_start     = 1'b0;
    w_sha3_done      = MuBi4False;

    // Disable aborts the current activity; a coincident window result is dropped.
    if (!enable_i && w_abortable) begin
      w_state_d        = StIdle;
      w_pass_d         = '0;
      w_fail_d         = '0;
      w_startup_done_d = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (fw_ov_ent_insert_i && !bypass_mode_i) begin
            w_sha3_start = 1'b1;
            w_state_d    = fw_ov_sha3_start_i ? StFwInsertMsg : StFwInsertStart;
          end else if (bypass_mode_i && !fw_ov_ent_insert_i) begin
            w_state_d = StBootHtRunning;
          end else if (!bypass_mode_i) begin
            w_state_d = StStartupHtStart;
          end
        end
        StBootHtRunning: begin
          if (ht_done_pulse_i) begin
            if (ht_fail_pulse_i) begin
              w_pop     = bypass_stage_rdy_i;
              w_state_d = alert_thresh_fail_i ? StAlertState : StIdle;
            end else begin
              w_rst_alert = 1'b1;
              w_state_d   = StBootPostHtChk;
            end
          end
        end
        StBootPostHtChk: begin
          if (bypass_stage_rdy_i) begin
            w_pop     = 1'b1;
            w_push    = 1'b1;
            w_state_d = StBootPhaseDone;
          end
        end
        StBootPhaseDone: begin
          if (!fw_ov_ent_insert_i && ht_done_pulse_i) begin
            if (alert_thresh_fail_i) w_state_d = StAlertState;
            else if (!ht_fail_pulse_i) w_rst_alert = 1'b1;
          end
        end
        StStartupHtStart: begin
          w_sha3_start = 1'b1;
          w_pass_d     = '0;
          w_fail_d     = '0;
          w_state_d    = StStartupRun;
        end
        StStartupRun: begin
          if (ht_done_pulse_i) begin
            if (ht_fail_pulse_i) begin
              w_fail_d = w_fail_inc;
              w_pass_d = '0;
              if (w_fail_inc >= CntW'(StartupFailLimit)) w_state_d = StAlertState;
            end else begin
              w_pass_d    = w_pass_inc;
              w_fail_d    = '0;
              w_rst_alert = 1'b1;
              if (w_pass_inc >= CntW'(StartupWindows)) w_state_d = StSha3Process;
            end
          end
        end
        StContHtStart: begin
          w_sha3_start = 1'b1;
          w_pass_d     = '0;
          w_state_d    = StContHtRunning;
        end
        StContHtRunning: begin
          if (ht_done_pulse_i) begin
            if (alert_thresh_fail_i) begin
              w_state_d = StAlertState;
            end else if (!ht_fail_pulse_i) begin
              w_pass_d    = w_pass_inc;
              w_rst_alert = 1'b1;
              if (w_pass_inc >= CntW'(ContWindowsPerSeed)) w_state_d = StSha3Process;
            end
          end
        end
        StFwInsertStart: if (fw_ov_sha3_start_i)  w_state_d = StFwInsertMsg;
        StFwInsertMsg:   if (!fw_ov_sha3_start_i) w_state_d = StSha3Process;
        StSha3Process:   w_state_d = StSha3Valid;
        StSha3Valid:     if (sha3_state_vld_i) w_state_d = StSha3Done;
        StSha3Done: begin
          w_sha3_done      = MuBi4True;
          w_push           = enable_i;
          w_startup_done_d = 1'b1;
          w_state_d        = StSha3MsgDone;
        end
        StSha3MsgDone: begin
          w_state_d = (!enable_i || fw_ov_ent_insert_i) ? StIdle : StContHtStart;
        end
        StAlertState:    w_state_d = StAlertHang;
        StAlertHang:     w_state_d = StAlertHang;
        StError:         w_state_d = StError;
        default:         w_state_d = StError;
      endcase
    end

    if (local_escalate_i) w_state_d = StError;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= StIdle;
      r_pass_cnt     <= '0;
      r_fail_cnt     <= '0;
      r_startup_done <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_pass_cnt     <= w_pass_d;
      r_fail_cnt     <= w_fail_d;
      r_startup_done <= w_startup_done_d;
    end
  end

  assign rst_alert_cntr_o   = w_rst_alert;
  assign main_stage_push_o  = w_push;
  assign bypass_stage_pop_o = w_pop;
  assign sha3_start_o       = w_sha3_start;
  assign sha3_done_o        = w_sha3_done;
  assign sha3_process_o     = (r_state == StSha3Process);
  assign boot_phase_done_o  = (r_state == StBootPhaseDone);
  assign main_sm_alert_o    = (r_state == StAlertState);
  assign main_sm_idle_o     = (r_state == StIdle);
  assign main_sm_err_o      = (r_state == StError);
  assign startup_done_o     = r_startup_done;
  assign pass_cnt_o         = r_pass_cnt;
  assign fail_cnt_o         = r_fail_cnt;

endmodule

// File: tb/tb_entropy_src_seed_sm.sv
// Randomized bench for entropy_src_seed_sm: window outcomes are drawn at random and
// judged against consecutive-run arithmetic for startup, continuous and boot flows.
module tb_entropy_src_seed_sm;
  localparam int N = 3;
  localparam int M = 2;
  localparam int K = 4;
  localparam int W = 4;
  localparam logic [3:0] MB_TRUE  = 4'h6;
  localparam logic [3:0] MB_FALSE = 4'h9;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic enable_i, bypass_mode_i, fw_ov_ent_insert_i, fw_ov_sha3_start_i;
  logic ht_done_pulse_i, ht_fail_pulse_i, alert_thresh_fail_i;
  logic bypass_stage_rdy_i, sha3_state_vld_i, local_escalate_i;
  logic rst_alert_cntr_o, main_stage_push_o, bypass_stage_pop_o;
  logic boot_phase_done_o, sha3_start_o, sha3_process_o;
  logic [3:0] sha3_done_o;
  logic startup_done_o;
  logic [W-1:0] pass_cnt_o, fail_cnt_o;
  logic main_sm_alert_o, main_sm_idle_o, main_sm_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  entropy_src_seed_sm #(
    .StartupWindows(N), .StartupFailLimit(M), .ContWindowsPerSeed(K), .CntW(W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .bypass_mode_i(bypass_mode_i),
    .fw_ov_ent_insert_i(fw_ov_ent_insert_i), .fw_ov_sha3_start_i(fw_ov_sha3_start_i),
    .ht_done_pulse_i(ht_done_pulse_i), .ht_fail_pulse_i(ht_fail_pulse_i),
    .alert_thresh_fail_i(alert_thresh_fail_i), .bypass_stage_rdy_i(bypass_stage_rdy_i),
    .sha3_state_vld_i(sha3_state_vld_i), .local_escalate_i(local_escalate_i),
    .rst_alert_cntr_o(rst_alert_cntr_o), .main_stage_push_o(main_stage_push_o),
    .bypass_stage_pop_o(bypass_stage_pop_o), .boot_phase_done_o(boot_phase_done_o),
    .sha3_start_o(sha3_start_o), .sha3_process_o(sha3_process_o), .sha3_done_o(sha3_done_o),
    .startup_done_o(startup_done_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .main_sm_alert_o(main_sm_alert_o), .main_sm_idle_o(main_sm_idle_o),
    .main_sm_err_o(main_sm_err_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Feed windows until the model predicts a seed (1) or an alert (2).
  task automatic run_windows(input bit cont, output int outcome);
    int np, nf, gap;
    bit fl, thr;
    np = 0; nf = 0; outcome = 0;
    for (int w = 0; w < 40 && outcome == 0; w++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        #2;
        check_val("gap_rst_alert", rst_alert_cntr_o, 0);
        check_val("gap_process", sha3_process_o, 0);
        tick();
      end
      fl  = (w < 30) && ($urandom_range(0, 99) < 35);
      thr = cont && fl && ($urandom_range(0, 99) < 20);
      ht_done_pulse_i = 1'b1; ht_fail_pulse_i = fl; alert_thresh_fail_i = thr;
      #2;
      check_val(cont ? "cont_rst_alert" : "start_rst_alert", rst_alert_cntr_o, !fl);
      tick();
      ht_done_pulse_i = 1'b0; ht_fail_pulse_i = 1'b0; alert_thresh_fail_i = 1'b0;
      if (cont) begin
        if (thr) outcome = 2;
        else if (!fl) begin
          np++;
          if (np == K) outcome = 1;
        end
        if (outcome != 2) check_val("cont_pass_cnt", pass_cnt_o, np);
      end else begin
        if (fl) begin
          nf++; np = 0;
          if (nf == M) outcome = 2;
        end else begin
          np++; nf = 0;
          if (np == N) outcome = 1;
        end
        check_val("start_pass_cnt", pass_cnt_o, np);
        check_val("start_fail_cnt", fail_cnt_o, nf);
      end
    end
    if (outcome == 0) check_val("window_budget", 0, 1);
  endtask

  // Entered in the Sha3Process cycle.
  task automatic finish_seed(input bit fw);
    int d;
    d = $urandom_range(0, 3);
    #2;
    check_val("process", sha3_process_o, 1);
    check_val("process_push", main_stage_push_o, 0);
    tick();
    repeat (d) begin
      #2;
      check_val("vld_wait_process", sha3_process_o, 0);
      check_val("vld_wait_done", sha3_done_o, MB_FALSE);
      check_val("vld_wait_push", main_stage_push_o, 0);
      tick();
    end
    sha3_state_vld_i = 1'b1;
    #2;
    tick();
    sha3_state_vld_i = 1'b0;
    #2;
    check_val("seed_push", main_stage_push_o, 1);
    check_val("seed_mubi", sha3_done_o, MB_TRUE);
    tick();
    #2;
    check_val("startup_done", startup_done_o, 1);
    check_val("msgdone_push", main_stage_push_o, 0);
    check_val("msgdone_mubi", sha3_done_o, MB_FALSE);
    tick();
    if (!fw) begin
      #2;
      check_val("cont_start", sha3_start_o, 1);
      tick();
      check_val("cont_pass_clr", pass_cnt_o, 0);
    end
  endtask

  // Entered in the AlertState cycle; leaves the DUT idle with enable low.
  task automatic finish_alert();
    #2;
    check_val("alert_pulse", main_sm_alert_o, 1);
    tick();
    repeat ($urandom_range(1, 4)) begin
      #2;
      check_val("hang_alert", main_sm_alert_o, 0);
      check_val("hang_idle", main_sm_idle_o, 0);
      tick();
    end
    enable_i = 1'b0;
    #2;
    tick();
    check_val("hang_exit_idle", main_sm_idle_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    rst_ni = 1'b0;
    enable_i = 0; bypass_mode_i = 0; fw_ov_ent_insert_i = 0; fw_ov_sha3_start_i = 0;
    ht_done_pulse_i = 0; ht_fail_pulse_i = 0; alert_thresh_fail_i = 0;
    bypass_stage_rdy_i = 0; sha3_state_vld_i = 0; local_escalate_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_idle", main_sm_idle_o, 1);
    check_val("rst_mubi", sha3_done_o, MB_FALSE);
    check_val("rst_err", main_sm_err_o, 0);
    check_val("rst_alert", main_sm_alert_o, 0);
    check_val("rst_pass", pass_cnt_o, 0);
    check_val("rst_fail", fail_cnt_o, 0);
    check_val("rst_startup_done", startup_done_o, 0);
    check_val("rst_strobes", {rst_alert_cntr_o, main_stage_push_o, bypass_stage_pop_o,
                              boot_phase_done_o, sha3_start_o, sha3_process_o}, 0);
    rst_ni = 1'b1;
    tick();

    // Bypass boot with a passing window and a slow bypass stage.
    enable_i = 1; bypass_mode_i = 1;
    tick();
    tick();
    ht_done_pulse_i = 1;
    #2;
    check_val("boot_rst_alert", rst_alert_cntr_o, 1);
    check_val("boot_pop_early", bypass_stage_pop_o, 0);
    tick();
    ht_done_pulse_i = 0;
    repeat (5) begin
      #2;
      check_val("boot_wait_pop", bypass_stage_pop_o, 0);
      check_val("boot_wait_push", main_stage_push_o, 0);
      tick();
    end
    bypass_stage_rdy_i = 1;
    #2;
    check_val("boot_pop", bypass_stage_pop_o, 1);
    check_val("boot_push", main_stage_push_o, 1);
    tick();
    bypass_stage_rdy_i = 0;
    check_val("boot_phase_done", boot_phase_done_o, 1);
    ht_done_pulse_i = 1;
    #2;
    check_val("bpd_rst_alert", rst_alert_cntr_o, 1);
    tick();
    ht_fail_pulse_i = 1; alert_thresh_fail_i = 1;
    #2;
    tick();
    ht_done_pulse_i = 0; ht_fail_pulse_i = 0; alert_thresh_fail_i = 0;
    finish_alert();

    // Bypass boot with a failing window and no threshold: pop then back to Idle.
    enable_i = 1;
    tick();
    ht_done_pulse_i = 1; ht_fail_pulse_i = 1; bypass_stage_rdy_i = 1;
    #2;
    check_val("bootfail_pop", bypass_stage_pop_o, 1);
    check_val("bootfail_push", main_stage_push_o, 0);
    tick();
    ht_done_pulse_i = 0; ht_fail_pulse_i = 0; bypass_stage_rdy_i = 0;
    check_val("bootfail_idle", main_sm_idle_o, 1);
    enable_i = 0; bypass_mode_i = 0;
    tick();

    // Firmware override insertion.
    enable_i = 1; fw_ov_ent_insert_i = 1;
    #2;
    check_val("fw_sha3_start", sha3_start_o, 1);
    tick();
    #2;
    check_val("fw_start_wait", sha3_start_o, 0);
    fw_ov_sha3_start_i = 1;
    tick();
    repeat (2) begin
      #2;
      check_val("fw_msg_process", sha3_process_o, 0);
      tick();
    end
    fw_ov_sha3_start_i = 0;
    tick();
    finish_seed(1'b1);
    check_val("fw_back_idle", main_sm_idle_o, 1);
    enable_i = 0; fw_ov_ent_insert_i = 0;
    tick();

    // Disable coinciding with a startup window result.
    enable_i = 1;
    tick();
    tick();
    ht_done_pulse_i = 1;
    #2;
    tick();
    check_val("dis_pass_before", pass_cnt_o, 1);
    enable_i = 0;
    #2;
    tick();
    ht_done_pulse_i = 0;
    check_val("dis_idle", main_sm_idle_o, 1);
    check_val("dis_pass_clr", pass_cnt_o, 0);
    check_val("dis_fail_clr", fail_cnt_o, 0);

    // Randomized startup / continuous rounds.
    for (int r = 0; r < 8; r++) begin
      enable_i = 0;
      tick();
      tick();
      check_val("round_idle", main_sm_idle_o, 1);
      check_val("round_startup_done_clr", startup_done_o, 0);
      enable_i = 1;
      #2;
      check_val("idle_no_start", sha3_start_o, 0);
      tick();
      #2;
      check_val("startup_sha3_start", sha3_start_o, 1);
      tick();
      check_val("startup_cnt_clr", pass_cnt_o, 0);
      run_windows(1'b0, oc);
      if (oc == 1) begin
        finish_seed(1'b0);
        for (int s = 0; s < 2 && oc == 1; s++) begin
          run_windows(1'b1, oc);
          if (oc == 1) finish_seed(1'b0);
          else finish_alert();
        end
        if (oc == 1) begin
          enable_i = 0;
          #2;
          tick();
          check_val("cont_disable_idle", main_sm_idle_o, 1);
          check_val("cont_disable_sd", startup_done_o, 0);
        end
      end else begin
        finish_alert();
      end
    end

    // Escalation during Sha3Valid is terminal until reset.
    enable_i = 1; fw_ov_ent_insert_i = 1; fw_ov_sha3_start_i = 1;
    tick();
    fw_ov_sha3_start_i = 0;
    tick();
    tick();
    check_val("esc_pre_err", main_sm_err_o, 0);
    local_escalate_i = 1;
    #2;
    tick();
    local_escalate_i = 0;
    for (int i = 0; i < 4; i++) begin
      enable_i = i[0];
      #2;
      check_val("esc_err_held", main_sm_err_o, 1);
      check_val("esc_not_idle", main_sm_idle_o, 0);
      tick();
    end
    rst_ni = 0;
    #2;
    check_val("esc_rst_idle", main_sm_idle_o, 1);
    check_val("esc_rst_err", main_sm_err_o, 0);
    rst_ni = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
